// File: rtl/bxu_loader.sv
// Boot sequencer: streams a length-prefixed image into code RAM, zeroes data RAM, then releases the core.
// Code write lands one cycle after its high byte; in_ready is a state decode, so in_valid gaps simply stall.
module bxu_loader #(
  parameter int DATA_BITWIDTH    = 8,
  parameter int CODE_BITWIDTH    = 16,
  parameter int ADDR_BITWIDTH    = 16,
  parameter int CODE_DEPTH       = 4096,
  parameter int DATA_CLEAR_WORDS = 256
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     halt,
  input  logic [DATA_BITWIDTH-1:0] in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [ADDR_BITWIDTH-1:0] code_wr_addr,
  output logic [CODE_BITWIDTH-1:0] code_wr_data,
  output logic                     code_wr,
  output logic [ADDR_BITWIDTH-1:0] data_wr_addr,
  output logic [DATA_BITWIDTH-1:0] data_wr_data,
  output logic                     data_wr,
  output logic                     core_rst_n,
  output logic                     busy,
  output logic                     done,
  output logic                     err
);

  // One spare counter bit so N == 2^ADDR_BITWIDTH does not wrap.
  localparam int CW = ADDR_BITWIDTH + 1;
  localparam int LW = 2 * DATA_BITWIDTH;
  localparam logic [CW-1:0] CLR_N   = CW'(DATA_CLEAR_WORDS);
  localparam logic [LW:0]   DEPTH_L = (LW+1)'(CODE_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_LO, S_LEN_HI, S_CODE_LO, S_CODE_HI, S_CLEAR, S_RUN, S_ERR
  } state_t;

  state_t                   r_state;
  logic [DATA_BITWIDTH-1:0] r_len_lo;
  logic [DATA_BITWIDTH-1:0] r_code_lo;
  logic [CW-1:0]            r_len;
  logic [CW-1:0]            r_idx;
  logic [CW-1:0]            r_clr;
  logic [ADDR_BITWIDTH-1:0] r_code_addr;
  logic [CODE_BITWIDTH-1:0] r_code_data;
  logic                     r_code_wr;
  logic [ADDR_BITWIDTH-1:0] r_data_addr;
  logic                     r_data_wr;
  logic                     r_core_rst_n;
  logic                     r_busy;
  logic                     r_done;
  logic                     r_err;

  logic                     w_accept;
  logic [LW-1:0]            w_len;
  logic                     w_len_bad;
  logic [CW-1:0]            w_idx_nxt;

  assign in_ready  = (r_state == S_LEN_LO) || (r_state == S_LEN_HI) ||
                     (r_state == S_CODE_LO) || (r_state == S_CODE_HI);
  assign w_accept  = in_valid && in_ready;
  assign w_len     = {in_data, r_len_lo};
  assign w_len_bad = (w_len == '0) || ({1'b0, w_len} > DEPTH_L);
  assign w_idx_nxt = r_idx + CW'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_len_lo     <= '0;
      r_code_lo    <= '0;
      r_len        <= '0;
      r_idx        <= '0;
      r_clr        <= '0;
      r_code_addr  <= '0;
      r_code_data  <= '0;
      r_code_wr    <= 1'b0;
      r_data_addr  <= '0;
      r_data_wr    <= 1'b0;
      r_core_rst_n <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_code_wr <= 1'b0;
      r_data_wr <= 1'b0;
      if (halt) begin
        // Clearing the strobe here also drops a code write accepted this same cycle.
        r_state      <= S_IDLE;
        r_core_rst_n <= 1'b0;
        r_done       <= 1'b0;
        r_busy       <= 1'b0;
        r_err        <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (start) begin
              r_state <= S_LEN_LO;
              r_busy  <= 1'b1;
            end
          end
          S_LEN_LO: begin
            if (w_accept) begin
              r_len_lo <= in_data;
              r_state  <= S_LEN_HI;
            end
          end
          S_LEN_HI: begin
            if (w_accept) begin
              if (w_len_bad) begin
                r_state <= S_ERR;
                r_err   <= 1'b1;
                r_busy  <= 1'b0;
              end else begin
                r_len   <= CW'(w_len);
                r_idx   <= '0;
                r_state <= S_CODE_LO;
              end
            end
          end
          S_CODE_LO: begin
            if (w_accept) begin
              r_code_lo <= in_data;
              r_state   <= S_CODE_HI;
            end
          end
          S_CODE_HI: begin
            if (w_accept) begin
              r_code_wr   <= 1'b1;
              r_code_addr <= r_idx[ADDR_BITWIDTH-1:0];
              r_code_data <= CODE_BITWIDTH'({in_data, r_code_lo});
              if (w_idx_nxt == r_len) begin
                r_clr   <= '0;
                r_state <= S_CLEAR;
              end else begin
                r_idx   <= w_idx_nxt;
                r_state <= S_CODE_LO;
              end
            end
          end
          S_CLEAR: begin
            // Release only after the last clear write has been issued.
            if (r_clr == CLR_N) begin
              r_state      <= S_RUN;
              r_core_rst_n <= 1'b1;
              r_done       <= 1'b1;
              r_busy       <= 1'b0;
            end else begin
              r_data_wr   <= 1'b1;
              r_data_addr <= r_clr[ADDR_BITWIDTH-1:0];
              r_clr       <= r_clr + CW'(1);
            end
          end
          S_RUN: begin
            r_state <= S_RUN;
          end
          S_ERR: begin
            if (start) begin
              r_err   <= 1'b0;
              r_busy  <= 1'b1;
              r_state <= S_LEN_LO;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign code_wr_addr = r_code_addr;
  assign code_wr_data = r_code_data;
  assign code_wr      = r_code_wr;
  assign data_wr_addr = r_data_addr;
  assign data_wr_data = '0;
  assign data_wr      = r_data_wr;
  assign core_rst_n   = r_core_rst_n;
  assign busy         = r_busy;
  assign done         = r_done;
  assign err          = r_err;

endmodule

// File: tb/tb_bxu_loader.sv
// Bench for bxu_loader: table of load scenarios, randomized loads vs. a stream-level model, and corner sequences.
module tb_bxu_loader;
  localparam int DEPTH = 4;
  localparam int CLR   = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        halt = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] code_wr_addr;
  logic [15:0] code_wr_data;
  logic        code_wr;
  logic [15:0] data_wr_addr;
  logic [7:0]  data_wr_data;
  logic        data_wr;
  logic        core_rst_n;
  logic        busy;
  logic        done;
  logic        err;

  bxu_loader #(
    .DATA_BITWIDTH(8), .CODE_BITWIDTH(16), .ADDR_BITWIDTH(16),
    .CODE_DEPTH(DEPTH), .DATA_CLEAR_WORDS(CLR)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .halt(halt),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .code_wr_addr(code_wr_addr), .code_wr_data(code_wr_data), .code_wr(code_wr),
    .data_wr_addr(data_wr_addr), .data_wr_data(data_wr_data), .data_wr(data_wr),
    .core_rst_n(core_rst_n), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] code_q[$];
  logic [15:0] data_q[$];
  logic [7:0]  stim_q[$];
  logic        nonzero_seen = 1'b0;
  logic        rdy_in_clear = 1'b0;

  always @(negedge clk) begin
    if (code_wr) code_q.push_back({code_wr_addr, code_wr_data});
    if (data_wr) begin
      data_q.push_back(data_wr_addr);
      if (data_wr_data != 8'h00) nonzero_seen = 1'b1;
      if (in_ready) rdy_in_clear = 1'b1;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    repeat (gap) begin @(posedge clk); #1; end
    in_valid = 1'b1;
    in_data  = b;
    t = 0;
    while (!in_ready && t < 50) begin @(posedge clk); #1; t++; end
    chk("byte_accept", 64'(t < 50), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic pulse(input logic s, input logic h);
    start = s;
    halt  = h;
    @(posedge clk); #1;
    start = 1'b0;
    halt  = 1'b0;
  endtask

  // Drives stim_q as one load and checks against the model: length from the first two bytes,
  // word i = {byte 2i+3, byte 2i+2} at address i, then CLR zero writes at 0..CLR-1.
  task automatic do_load(input int gap, input string tag);
    int n, t, nexp;
    logic exp_err;
    if (done) pulse(1'b0, 1'b1);
    code_q.delete();
    data_q.delete();
    pulse(1'b1, 1'b0);
    n = int'(stim_q[0]) + 256 * int'(stim_q[1]);
    exp_err = (n == 0) || (n > DEPTH);
    foreach (stim_q[i]) send_byte(stim_q[i], gap);
    t = 0;
    while (!(done || err) && t < 500) begin @(posedge clk); #1; t++; end
    chk({tag, "_finish"}, 64'(t < 500), 64'd1);
    @(negedge clk);
    chk({tag, "_err"}, 64'(err), 64'(exp_err));
    chk({tag, "_done"}, 64'(done), 64'(!exp_err));
    chk({tag, "_core_rst_n"}, 64'(core_rst_n), 64'(!exp_err));
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    nexp = exp_err ? 0 : n;
    chk({tag, "_code_cnt"}, 64'(code_q.size()), 64'(nexp));
    for (int i = 0; i < nexp && i < code_q.size(); i++)
      chk({tag, "_code_wr"}, 64'(code_q[i]), {32'd0, 16'(i), stim_q[3+2*i], stim_q[2+2*i]});
    nexp = exp_err ? 0 : CLR;
    chk({tag, "_data_cnt"}, 64'(data_q.size()), 64'(nexp));
    for (int i = 0; i < nexp && i < data_q.size(); i++)
      chk({tag, "_data_addr"}, 64'(data_q[i]), 64'(i));
  endtask

  typedef struct {
    logic [7:0]       len_lo;
    logic [7:0]       len_hi;
    logic [3:0][15:0] w;
    int               gap;
    logic             exp_err;
    int               exp_words;
  } vec_t;

  vec_t tbl[7];

  initial begin
    int t;
    tbl[0] = '{8'h02, 8'h00, {16'h0, 16'h0, 16'h5678, 16'h1234}, 0, 1'b0, 2};
    tbl[1] = '{8'h00, 8'h00, {16'h0, 16'h0, 16'h0, 16'h0}, 0, 1'b1, 0};
    tbl[2] = '{8'h05, 8'h00, {16'h0, 16'h0, 16'h0, 16'h0}, 0, 1'b1, 0};
    tbl[3] = '{8'h01, 8'h00, {16'h0, 16'h0, 16'h0, 16'hBBAA}, 0, 1'b0, 1};
    tbl[4] = '{8'h02, 8'h00, {16'h0, 16'h0, 16'h5678, 16'h1234}, 3, 1'b0, 2};
    tbl[5] = '{8'h04, 8'h00, {16'hD00D, 16'hC0DE, 16'hBEEF, 16'hCAFE}, 1, 1'b0, 4};
    tbl[6] = '{8'h00, 8'h01, {16'h0, 16'h0, 16'h0, 16'h0}, 0, 1'b1, 0};

    #1 rst = 1'b1;
    #11;
    chk("reset_flags", 64'({core_rst_n, busy, done, err, code_wr, data_wr, in_ready}), 64'd0);
    chk("reset_addr", {code_wr_addr, code_wr_data, data_wr_addr, 8'h00, data_wr_data}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("idle_in_ready", 64'(in_ready), 64'd0);

    for (int k = 0; k < 7; k++) begin
      stim_q.delete();
      stim_q.push_back(tbl[k].len_lo);
      stim_q.push_back(tbl[k].len_hi);
      for (int j = 0; j < tbl[k].exp_words; j++) begin
        stim_q.push_back(tbl[k].w[j][7:0]);
        stim_q.push_back(tbl[k].w[j][15:8]);
      end
      do_load(tbl[k].gap, $sformatf("tbl%0d", k));
      chk($sformatf("tbl%0d_err_tbl", k), 64'(err), 64'(tbl[k].exp_err));
      chk($sformatf("tbl%0d_words_tbl", k), 64'(code_q.size()), 64'(tbl[k].exp_words));
    end

    // Restore a running core, then poke it: offered bytes, start, halt, start+halt.
    stim_q.delete();
    stim_q = '{8'h01, 8'h00, 8'h11, 8'h22};
    do_load(0, "run");
    code_q.delete();
    in_valid = 1'b1;
    in_data  = 8'hFF;
    repeat (3) begin @(posedge clk); #1; end
    chk("run_in_ready", 64'(in_ready), 64'd0);
    in_valid = 1'b0;
    pulse(1'b1, 1'b0);
    @(negedge clk);
    chk("run_start_ignored", 64'({done, busy, core_rst_n}), 64'b101);
    chk("run_no_writes", 64'(code_q.size()), 64'd0);
    @(posedge clk); #1;
    pulse(1'b0, 1'b1);
    @(negedge clk);
    chk("halt_run", 64'({core_rst_n, done, busy}), 64'd0);
    @(posedge clk); #1;
    pulse(1'b1, 1'b1);
    @(negedge clk);
    chk("start_halt_same", 64'({busy, in_ready}), 64'd0);

    // Halt on the cycle the final high byte is accepted: its write must vanish.
    @(posedge clk); #1;
    pulse(1'b1, 1'b0);
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    send_byte(8'hAA, 0);
    code_q.delete();
    in_valid = 1'b1;
    in_data  = 8'hBB;
    halt     = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    halt     = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    chk("halt_code_hi_no_wr", 64'(code_q.size()), 64'd0);
    chk("halt_code_hi_idle", 64'({busy, in_ready}), 64'd0);

    // Halt during the clear at address 2.
    code_q.delete();
    data_q.delete();
    pulse(1'b1, 1'b0);
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    t = 0;
    do begin @(negedge clk); t++; end while (!(data_wr && data_wr_addr == 16'd2) && t < 100);
    chk("clear_reach_addr2", 64'(t < 100), 64'd1);
    halt = 1'b1;
    @(posedge clk); #1;
    halt = 1'b0;
    @(negedge clk);
    chk("halt_clear_data_wr", 64'({data_wr, busy, in_ready}), 64'd0);
    repeat (8) @(negedge clk);
    chk("halt_clear_no_done", 64'(done), 64'd0);
    chk("halt_clear_wr_cnt", 64'(data_q.size()), 64'd3);
    @(posedge clk); #1;
    stim_q = '{8'h02, 8'h00, 8'h0F, 8'hF0, 8'h5A, 8'hA5};
    do_load(0, "after_halt");

    // Asynchronous reset between the low and high code bytes.
    pulse(1'b0, 1'b1);
    pulse(1'b1, 1'b0);
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    send_byte(8'h55, 0);
    code_q.delete();
    #2 rst = 1'b1;
    #1;
    chk("arst_outputs", 64'({core_rst_n, busy, done, err, code_wr, data_wr, in_ready}), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("arst_no_code_wr", 64'(code_q.size()), 64'd0);
    @(posedge clk); #1;
    stim_q = '{8'h02, 8'h00, 8'h34, 8'h12, 8'h78, 8'h56};
    do_load(0, "after_arst");

    // Random loads, including out-of-range lengths.
    for (int r = 0; r < 20; r++) begin
      int n;
      stim_q.delete();
      n = $urandom_range(0, DEPTH + 1);
      stim_q.push_back(8'(n));
      if ($urandom_range(0, 4) == 0) stim_q.push_back(8'($urandom_range(1, 255)));
      else stim_q.push_back(8'h00);
      if (stim_q[1] == 8'h00 && n >= 1 && n <= DEPTH)
        for (int j = 0; j < 2 * n; j++) stim_q.push_back(8'($urandom_range(0, 255)));
      do_load($urandom_range(0, 2), $sformatf("rnd%0d", r));
    end

    chk("clear_data_zero", 64'(nonzero_seen), 64'd0);
    chk("clear_in_ready_low", 64'(rdy_in_clear), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
